ycr_sram_arb: RTL and testbench

Two-requester arbiter and sequencer for one 1RW SRAM port (port-0: csb/web/addr/wmask/din plus dout). Accepts single-beat read/write requests from requester A and requester B with round-robin fairness. Drives registered SRAM control/data signals toward the SRAM phase mux. Times read-data capture for the configured SRAM read latency and launch phase.

---
 rtl/ycr_sram_arb.sv | 204 ++++++++++++++++++++
 tb/tb_ycr_sram_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr_sram_arb.sv
// Two-requester round-robin arbiter and sequencer for one 1RW SRAM port.
// Define YCR_SRAM_ARB_FIXPRIO_EN to give requester A fixed priority instead.
module ycr_sram_arb #(
   parameter int AW     = 9,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic              mem_clk_i,
   input  logic              mem_rst_i,
   input  logic              cfg_mem_lphase,

   input  logic              req_a_i,
   input  logic              we_a_i,
   input  logic [AW-1:0]     addr_a_i,
   input  logic [DW/8-1:0]   wmask_a_i,
   input  logic [DW-1:0]     wdata_a_i,
   output logic              ack_a_o,
   output logic              rvalid_a_o,
   output logic [DW-1:0]     rdata_a_o,

   input  logic              req_b_i,
   input  logic              we_b_i,
   input  logic [AW-1:0]     addr_b_i,
   input  logic [DW/8-1:0]   wmask_b_i,
   input  logic [DW-1:0]     wdata_b_i,
   output logic              ack_b_o,
   output logic              rvalid_b_o,
   output logic [DW-1:0]     rdata_b_o,

   output logic              mem_csb0_o,
   output logic              mem_web0_o,
   output logic [AW-1:0]     mem_addr0_o,
   output logic [DW/8-1:0]   mem_wmask0_o,
   output logic [DW-1:0]     mem_din0_o,
   input  logic [DW-1:0]     mem_dout0_i,

   output logic              busy_o
);

   localparam int MW = DW/8;
   localparam int CW = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RD   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            owner_q, owner_d;   // 0 = A, 1 = B
   logic            csb_q, csb_d;
   logic            web_q, web_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [MW-1:0]   wmask_q, wmask_d;
   logic [DW-1:0]   din_q, din_d;
   logic            rvalid_a_q, rvalid_a_d;
   logic            rvalid_b_q, rvalid_b_d;
   logic [DW-1:0]   rdata_a_q, rdata_b_q;

   logic            ack_a, ack_b;
   logic            win_we;
   logic [AW-1:0]   win_addr;
   logic [MW-1:0]   win_wmask;
   logic [DW-1:0]   win_wdata;
   logic [CW-1:0]   rd_cnt_init;

   // Handshake: a transfer happens in any cycle where req_x_i and ack_x_o
   // are both high; the requester keeps its fields stable until then.
`ifdef YCR_SRAM_ARB_FIXPRIO_EN
   always_comb begin
      ack_a = 1'b0;
      ack_b = 1'b0;
      if (!mem_rst_i && state_q == ST_IDLE) begin
         ack_a = req_a_i;
         ack_b = req_b_i & ~req_a_i;
      end
   end
`else
   logic last_b_q;   // last grant went to B

   always_comb begin
      ack_a = 1'b0;
      ack_b = 1'b0;
      if (!mem_rst_i && state_q == ST_IDLE) begin
         if (req_a_i && req_b_i) begin
            ack_a = last_b_q;
            ack_b = ~last_b_q;
         end else begin
            ack_a = req_a_i;
            ack_b = req_b_i;
         end
      end
   end

   always_ff @(posedge mem_clk_i or posedge mem_rst_i) begin
      if (mem_rst_i) begin
         last_b_q <= 1'b1;
      end else if (ack_a) begin
         last_b_q <= 1'b0;
      end else if (ack_b) begin
         last_b_q <= 1'b1;
      end
   end
`endif

   assign win_we      = ack_b ? we_b_i    : we_a_i;
   assign win_addr    = ack_b ? addr_b_i  : addr_a_i;
   assign win_wmask   = ack_b ? wmask_b_i : wmask_a_i;
   assign win_wdata   = ack_b ? wdata_b_i : wdata_a_i;

   // Negedge launch pushes the SRAM output one cycle later.
   assign rd_cnt_init = CW'(RD_LAT + 1) + {{(CW-1){1'b0}}, cfg_mem_lphase};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      csb_d      = 1'b1;
      web_d      = 1'b1;
      addr_d     = addr_q;
      wmask_d    = wmask_q;
      din_d      = din_q;
      rvalid_a_d = 1'b0;
      rvalid_b_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ack_a || ack_b) begin
               csb_d  = 1'b0;
               addr_d = win_addr;
               din_d  = win_wdata;
               if (win_we) begin
                  web_d   = 1'b0;
                  wmask_d = win_wmask;
               end else begin
                  wmask_d = '0;
                  state_d = ST_RD;
                  cnt_d   = rd_cnt_init;
                  owner_d = ack_b;
               end
            end
         end
         ST_RD: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d    = ST_IDLE;
               rvalid_a_d = ~owner_q;
               rvalid_b_d = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge mem_clk_i or posedge mem_rst_i) begin
      if (mem_rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         owner_q    <= 1'b0;
         csb_q      <= 1'b1;
         web_q      <= 1'b1;
         addr_q     <= '0;
         wmask_q    <= '0;
         din_q      <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         csb_q      <= csb_d;
         web_q      <= web_d;
         addr_q     <= addr_d;
         wmask_q    <= wmask_d;
         din_q      <= din_d;
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
      end
   end

   // Read data is captured in the same cycle the rvalid pulse is scheduled.
   always_ff @(posedge mem_clk_i or posedge mem_rst_i) begin
      if (mem_rst_i) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         if (rvalid_a_d) rdata_a_q <= mem_dout0_i;
         if (rvalid_b_d) rdata_b_q <= mem_dout0_i;
      end
   end

   assign ack_a_o      = ack_a;
   assign ack_b_o      = ack_b;
   assign rvalid_a_o   = rvalid_a_q;
   assign rvalid_b_o   = rvalid_b_q;
   assign rdata_a_o    = rdata_a_q;
   assign rdata_b_o    = rdata_b_q;
   assign mem_csb0_o   = csb_q;
   assign mem_web0_o   = web_q;
   assign mem_addr0_o  = addr_q;
   assign mem_wmask0_o = wmask_q;
   assign mem_din0_o   = din_q;
   assign busy_o       = (state_q == ST_RD);

endmodule

// File: tb/tb_ycr_sram_arb.sv
// Directed bench for ycr_sram_arb: vector table plus multi-cycle sequences.
// Honours YCR_SRAM_ARB_FIXPRIO_EN for the contention sequence.
module tb_ycr_sram_arb;

   logic        clk;
   logic        rst;
   logic        lphase;
   logic        req_a_i, we_a_i, req_b_i, we_b_i;
   logic [8:0]  addr_a_i, addr_b_i;
   logic [3:0]  wmask_a_i, wmask_b_i;
   logic [31:0] wdata_a_i, wdata_b_i;
   logic        ack_a_o, ack_b_o, rvalid_a_o, rvalid_b_o;
   logic [31:0] rdata_a_o, rdata_b_o;
   logic        mem_csb0_o, mem_web0_o;
   logic [8:0]  mem_addr0_o;
   logic [3:0]  mem_wmask0_o;
   logic [31:0] mem_din0_o;
   logic [31:0] mem_dout0_i;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   ycr_sram_arb #(.AW(9), .DW(32), .RD_LAT(1)) dut (
      .mem_clk_i(clk), .mem_rst_i(rst), .cfg_mem_lphase(lphase),
      .req_a_i(req_a_i), .we_a_i(we_a_i), .addr_a_i(addr_a_i),
      .wmask_a_i(wmask_a_i), .wdata_a_i(wdata_a_i),
      .ack_a_o(ack_a_o), .rvalid_a_o(rvalid_a_o), .rdata_a_o(rdata_a_o),
      .req_b_i(req_b_i), .we_b_i(we_b_i), .addr_b_i(addr_b_i),
      .wmask_b_i(wmask_b_i), .wdata_b_i(wdata_b_i),
      .ack_b_o(ack_b_o), .rvalid_b_o(rvalid_b_o), .rdata_b_o(rdata_b_o),
      .mem_csb0_o(mem_csb0_o), .mem_web0_o(mem_web0_o),
      .mem_addr0_o(mem_addr0_o), .mem_wmask0_o(mem_wmask0_o),
      .mem_din0_o(mem_din0_o), .mem_dout0_i(mem_dout0_i),
      .busy_o(busy_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: output register loads on a read cycle and holds otherwise
   logic [31:0] mem [0:511];
   logic [31:0] dout_q;
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      dout_q = 32'h0;
   end
   always @(posedge clk) begin
      if (!mem_csb0_o) begin
         if (!mem_web0_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_wmask0_o[b]) mem[mem_addr0_o][8*b +: 8] <= mem_din0_o[8*b +: 8];
         end else begin
            dout_q <= mem[mem_addr0_o];
         end
      end
   end
   assign mem_dout0_i = dout_q;

   // driver tasks
   task automatic set_a(input logic r, input logic w, input logic [8:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      req_a_i = r; we_a_i = w; addr_a_i = a; wdata_a_i = d; wmask_a_i = m;
   endtask

   task automatic set_b(input logic r, input logic w, input logic [8:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      req_b_i = r; we_b_i = w; addr_b_i = a; wdata_b_i = d; wmask_b_i = m;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard compare
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ra; logic wa; logic [8:0] aa; logic [31:0] da; logic [3:0] ma;
      logic        rb; logic wb; logic [8:0] ab; logic [31:0] db; logic [3:0] mb;
      logic        e_acka; logic e_ackb; logic e_csb; logic e_web;
      logic [8:0]  e_addr; logic [31:0] e_din; logic [3:0] e_wmask;
      logic        e_rva; logic e_rvb; logic e_busy;
      logic [31:0] e_rda; logic [31:0] e_rdb;
   } vec_t;

   vec_t vecs [9];
   logic [3:0] grant_a_pat;
   logic [8:0] prev_addr;

   initial begin
      // row: A inputs | B inputs | ack_a ack_b csb web addr din wmask | rva rvb busy rda rdb
      vecs[0] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b0,1'b0,9'h000,32'h0,4'h0,
                  1'b0,1'b0,1'b1,1'b1,9'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0,32'h0};
      vecs[1] = '{1'b1,1'b1,9'h005,32'hDEADBEEF,4'hF, 1'b0,1'b0,9'h000,32'h0,4'h0,
                  1'b1,1'b0,1'b1,1'b1,9'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,32'h0,32'h0};
      vecs[2] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b0,1'b0,9'h000,32'h0,4'h0,
                  1'b0,1'b0,1'b0,1'b0,9'h005,32'hDEADBEEF,4'hF, 1'b0,1'b0,1'b0,32'h0,32'h0};
      vecs[3] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b1,1'b0,9'h005,32'h11111111,4'hF,
                  1'b0,1'b1,1'b1,1'b1,9'h005,32'hDEADBEEF,4'hF, 1'b0,1'b0,1'b0,32'h0,32'h0};
      vecs[4] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b0,1'b0,9'h000,32'h0,4'h0,
                  1'b0,1'b0,1'b0,1'b1,9'h005,32'h11111111,4'h0, 1'b0,1'b0,1'b1,32'h0,32'h0};
      vecs[5] = '{1'b1,1'b1,9'h009,32'hCAFEF00D,4'h3, 1'b0,1'b0,9'h000,32'h0,4'h0,
                  1'b0,1'b0,1'b1,1'b1,9'h005,32'h11111111,4'h0, 1'b0,1'b0,1'b1,32'h0,32'h0};
      vecs[6] = '{1'b1,1'b1,9'h009,32'hCAFEF00D,4'h3, 1'b0,1'b0,9'h000,32'h0,4'h0,
                  1'b1,1'b0,1'b1,1'b1,9'h005,32'h11111111,4'h0, 1'b0,1'b1,1'b0,32'h0,32'hDEADBEEF};
      vecs[7] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b0,1'b0,9'h000,32'h0,4'h0,
                  1'b0,1'b0,1'b0,1'b0,9'h009,32'hCAFEF00D,4'h3, 1'b0,1'b0,1'b0,32'h0,32'hDEADBEEF};
      vecs[8] = '{1'b0,1'b0,9'h000,32'h0,4'h0, 1'b0,1'b0,9'h000,32'h0,4'h0,
                  1'b0,1'b0,1'b1,1'b1,9'h009,32'hCAFEF00D,4'h3, 1'b0,1'b0,1'b0,32'h0,32'hDEADBEEF};
`ifdef YCR_SRAM_ARB_FIXPRIO_EN
      grant_a_pat = 4'b1111;
`else
      grant_a_pat = 4'b0101;
`endif

      rst = 1'b1; lphase = 1'b0;
      set_a(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
      set_b(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
      repeat (2) @(posedge clk);
      #1 req_a_i = 1'b1;
      #1;
      chk("reset ack_a", 32'(ack_a_o), 32'h0);
      chk("reset csb", 32'(mem_csb0_o), 32'h1);
      chk("reset busy", 32'(busy_o), 32'h0);
      chk("reset addr", 32'(mem_addr0_o), 32'h0);
      chk("reset rvalid_a", 32'(rvalid_a_o), 32'h0);
      req_a_i = 1'b0;
      rst = 1'b0;
      step();

      // vector table: single write, read from B, request stalled during RD
      for (int i = 0; i < 9; i++) begin
         set_a(vecs[i].ra, vecs[i].wa, vecs[i].aa, vecs[i].da, vecs[i].ma);
         set_b(vecs[i].rb, vecs[i].wb, vecs[i].ab, vecs[i].db, vecs[i].mb);
         #1;
         chk($sformatf("row%0d ack_a", i), 32'(ack_a_o), 32'(vecs[i].e_acka));
         chk($sformatf("row%0d ack_b", i), 32'(ack_b_o), 32'(vecs[i].e_ackb));
         chk($sformatf("row%0d csb", i), 32'(mem_csb0_o), 32'(vecs[i].e_csb));
         if (vecs[i].e_csb == 1'b0)
            chk($sformatf("row%0d web", i), 32'(mem_web0_o), 32'(vecs[i].e_web));
         chk($sformatf("row%0d addr", i), 32'(mem_addr0_o), 32'(vecs[i].e_addr));
         chk($sformatf("row%0d din", i), mem_din0_o, vecs[i].e_din);
         chk($sformatf("row%0d wmask", i), 32'(mem_wmask0_o), 32'(vecs[i].e_wmask));
         chk($sformatf("row%0d rvalid_a", i), 32'(rvalid_a_o), 32'(vecs[i].e_rva));
         chk($sformatf("row%0d rvalid_b", i), 32'(rvalid_b_o), 32'(vecs[i].e_rvb));
         chk($sformatf("row%0d busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
         chk($sformatf("row%0d rdata_a", i), rdata_a_o, vecs[i].e_rda);
         chk($sformatf("row%0d rdata_b", i), rdata_b_o, vecs[i].e_rdb);
         step();
      end

      // negedge launch: one extra cycle, lphase toggling mid-read ignored
      set_b(1'b1, 1'b0, 9'h009, 32'h0, 4'h0);
      lphase = 1'b1;
      #1;
      chk("lph accept ack_b", 32'(ack_b_o), 32'h1);
      step();
      for (int k = 1; k <= 5; k++) begin
         set_b(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
         lphase = 1'(k % 2);
         #1;
         chk($sformatf("lph k%0d rvalid_b", k), 32'(rvalid_b_o), 32'(k == 4));
         chk($sformatf("lph k%0d busy", k), 32'(busy_o), 32'(k <= 3));
         chk($sformatf("lph k%0d csb", k), 32'(mem_csb0_o), 32'(k != 1));
         chk($sformatf("lph k%0d rdata_b", k), rdata_b_o, (k >= 4) ? 32'h0000F00D : 32'hDEADBEEF);
         chk($sformatf("lph k%0d rvalid_a", k), 32'(rvalid_a_o), 32'h0);
         step();
      end
      lphase = 1'b0;

      // contention after reset: both writes held for four cycles
      rst = 1'b1;
      #1;
      chk("rst2 csb", 32'(mem_csb0_o), 32'h1);
      step();
      rst = 1'b0;
      set_a(1'b1, 1'b1, 9'h010, 32'h0000000A, 4'hF);
      set_b(1'b1, 1'b1, 9'h020, 32'h0000000B, 4'hF);
      prev_addr = 9'h0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("arb k%0d ack_a", k), 32'(ack_a_o), 32'(grant_a_pat[k]));
         chk($sformatf("arb k%0d ack_b", k), 32'(ack_b_o), 32'(!grant_a_pat[k]));
         if (k > 0) chk($sformatf("arb k%0d addr", k), 32'(mem_addr0_o), 32'(prev_addr));
         prev_addr = grant_a_pat[k] ? 9'h010 : 9'h020;
         step();
      end
      set_a(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
      set_b(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
      #1;
      chk("arb last addr", 32'(mem_addr0_o), 32'(prev_addr));
      chk("arb last csb", 32'(mem_csb0_o), 32'h0);
      step();

      // reset in the second RD cycle discards the read
      set_a(1'b1, 1'b0, 9'h010, 32'h0, 4'h0);
      #1;
      chk("rstrd ack_a", 32'(ack_a_o), 32'h1);
      step();
      set_a(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
      #1;
      chk("rstrd busy t1", 32'(busy_o), 32'h1);
      step();
      rst = 1'b1;
      #1;
      chk("rstrd csb", 32'(mem_csb0_o), 32'h1);
      chk("rstrd busy", 32'(busy_o), 32'h0);
      set_a(1'b1, 1'b0, 9'h010, 32'h0, 4'h0);
      #1;
      chk("rstrd ack in reset", 32'(ack_a_o), 32'h0);
      set_a(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("rstrd k%0d rvalid_a", k), 32'(rvalid_a_o), 32'h0);
         chk($sformatf("rstrd k%0d rdata_a", k), rdata_a_o, 32'h0);
         step();
      end
      set_a(1'b1, 1'b1, 9'h040, 32'h00000077, 4'hF);
      #1;
      chk("rstrd next ack_a", 32'(ack_a_o), 32'h1);
      step();
      set_a(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
      #1;
      chk("rstrd next csb", 32'(mem_csb0_o), 32'h0);
      chk("rstrd next web", 32'(mem_web0_o), 32'h0);
      chk("rstrd next addr", 32'(mem_addr0_o), 32'h040);
      step();

      // read then write from A: write accepted in the rvalid cycle
      set_a(1'b1, 1'b0, 9'h010, 32'h0, 4'h0);
      #1;
      chk("b2b rd ack_a", 32'(ack_a_o), 32'h1);
      step();
      for (int k = 1; k <= 3; k++) begin
         set_a(1'b1, 1'b1, 9'h030, 32'h00000055, 4'hF);
         #1;
         chk($sformatf("b2b k%0d ack_a", k), 32'(ack_a_o), 32'(k == 3));
         chk($sformatf("b2b k%0d rvalid_a", k), 32'(rvalid_a_o), 32'(k == 3));
         step();
      end
      set_a(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);
      #1;
      chk("b2b rdata_a", rdata_a_o, 32'h0000000A);
      chk("b2b rdata_b", rdata_b_o, 32'h0);
      chk("b2b wr csb", 32'(mem_csb0_o), 32'h0);
      chk("b2b wr web", 32'(mem_web0_o), 32'h0);
      chk("b2b wr addr", 32'(mem_addr0_o), 32'h030);
      chk("b2b wr din", mem_din0_o, 32'h00000055);
      chk("b2b rvalid_a off", 32'(rvalid_a_o), 32'h0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
